reg_bus_master: RTL and testbench

Command sequencer that sits directly upstream of the register-file block and drives its WRITE/READ/ADDR/WRITE_DATA strobe bus. Host requests arrive on a valid/ready channel and are buffered in a small FIFO. They are issued to the register file strictly in order, one at a time. Read results are captured from READ_DATA after a fixed latency and returned on a valid/ready response channel.

---
 rtl/reg_bus_master.sv | 127 ++++++++++++
 tb/tb_reg_bus_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_master.sv
// Register-file command sequencer: buffers host read/write requests in a FIFO
// and issues them one at a time on the WRITE/READ strobe bus.
`timescale 1ns/1ps
module reg_bus_master #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WR,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              WRITE,
  output logic              READ,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] WRITE_DATA,
  input  logic [DATA_W-1:0] READ_DATA,
  output logic              BUSY
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam int CW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [EW-1:0] fifo [FIFO_DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [EW-1:0] head;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          push;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign REQ_READY = !full && !RST;
  assign push      = REQ_VALID && REQ_READY;
  assign head      = fifo[rd_ptr[PW-1:0]];
  assign BUSY      = !empty || (state != IDLE);

  always_ff @(posedge CLK) begin
    if (push)
      fifo[wr_ptr[PW-1:0]] <= {REQ_WR, REQ_ADDR, REQ_DATA};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      wr_ptr <= '0;
    else if (push)
      wr_ptr <= wr_ptr + (PW+1)'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      cnt        <= '0;
      WRITE      <= 1'b0;
      READ       <= 1'b0;
      ADDR       <= '0;
      WRITE_DATA <= '0;
      RSP_VALID  <= 1'b0;
      RSP_DATA   <= '0;
    end else begin
      WRITE <= 1'b0;
      READ  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            rd_ptr <= rd_ptr + (PW+1)'(1);
            ADDR   <= head[DATA_W +: ADDR_W];
            if (head[EW-1]) begin
              WRITE      <= 1'b1;
              WRITE_DATA <= head[DATA_W-1:0];
            end else begin
              READ <= 1'b1;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (READ) begin
            if (RD_LAT == 0) begin
              RSP_DATA  <= READ_DATA;
              RSP_VALID <= 1'b1;
              state     <= RESP;
            end else begin
              cnt   <= CW'(RD_LAT);
              state <= WAIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            RSP_DATA  <= READ_DATA;
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: one instance with RD_LAT=0 and one
// with RD_LAT=3, each attached to its own small register-file model.
`timescale 1ns/1ps
module tb_reg_bus_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic       v0 = 0, wr0 = 0, rr0 = 0;
  logic [2:0] a0 = 0;
  logic [1:0] d0 = 0;
  logic       rdy0, rv0, w0, r0, busy0;
  logic [1:0] rd0, wd0, rdata0;
  logic [2:0] ad0;

  logic       v1 = 0, wr1 = 0, rr1 = 0;
  logic [2:0] a1 = 0;
  logic [1:0] d1 = 0;
  logic       rdy1, rv1, w1, r1, busy1;
  logic [1:0] rd1, wd1, rdata1;
  logic [2:0] ad1;

  reg_bus_master u0 (
    .CLK(clk), .RST(rst),
    .REQ_VALID(v0), .REQ_READY(rdy0), .REQ_WR(wr0),
    .REQ_ADDR(a0), .REQ_DATA(d0),
    .RSP_VALID(rv0), .RSP_READY(rr0), .RSP_DATA(rd0),
    .WRITE(w0), .READ(r0), .ADDR(ad0), .WRITE_DATA(wd0),
    .READ_DATA(rdata0), .BUSY(busy0)
  );

  reg_bus_master #(.RD_LAT(3)) u1 (
    .CLK(clk), .RST(rst),
    .REQ_VALID(v1), .REQ_READY(rdy1), .REQ_WR(wr1),
    .REQ_ADDR(a1), .REQ_DATA(d1),
    .RSP_VALID(rv1), .RSP_READY(rr1), .RSP_DATA(rd1),
    .WRITE(w1), .READ(r1), .ADDR(ad1), .WRITE_DATA(wd1),
    .READ_DATA(rdata1), .BUSY(busy1)
  );

  logic [1:0] rf0 [8];
  always @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 8; i++) rf0[i] <= 2'b00;
      rf0[3] <= 2'b11;
    end else if (w0) rf0[ad0] <= wd0;
  assign rdata0 = rf0[ad0];

  // Delayed-read model: valid data only in the RD_LAT-th cycle after READ.
  logic [1:0] rf1 [8];
  logic [2:0] pv;
  logic [1:0] pd [3];
  always @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 8; i++) rf1[i] <= 2'b00;
      rf1[5] <= 2'b01;
      pv <= 3'b000;
      for (int i = 0; i < 3; i++) pd[i] <= 2'b00;
    end else begin
      if (w1) rf1[ad1] <= wd1;
      pv    <= {pv[1:0], r1};
      pd[0] <= rf1[ad1];
      pd[1] <= pd[0];
      pd[2] <= pd[1];
    end
  assign rdata1 = pv[2] ? pd[2] : 2'b10;

  logic [5:0] slog[$];
  int         scyc[$];
  logic [1:0] rlog[$];
  int         both = 0;
  int         s1_cnt = 0;
  int         rv1_cnt = 0;
  always @(negedge clk) begin
    if (w0 || r0) begin
      slog.push_back({w0, ad0, wd0});
      scyc.push_back(cyc);
    end
    if ((w0 && r0) || (w1 && r1)) both++;
    if (rv0 && rr0) rlog.push_back(rd0);
    if (w1 || r1) s1_cnt++;
    if (rv1) rv1_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic wr, input logic [2:0] a,
                       input logic [1:0] d);
    int k = 0;
    v0 = 1'b1; wr0 = wr; a0 = a; d0 = d;
    while (!rdy0 && k < 100) begin tick(); k++; end
    if (k >= 100) check("push0_timeout", 32'd0, 32'd1);
    tick();
    v0 = 1'b0;
  endtask

  initial begin
    int n, k, hs, sb, rb, s1b, rv1b;
    logic [1:0] exp_q[$];
    logic [5:0] wexp [4];
    wexp = '{6'b1_001_01, 6'b1_010_10, 6'b1_100_11, 6'b1_101_01};

    repeat (3) tick();
    check("rst_req_ready", rdy0, 0);
    check("rst_rsp_valid", rv0, 0);
    check("rst_rsp_data", rd0, 0);
    check("rst_write", w0, 0);
    check("rst_read", r0, 0);
    check("rst_addr", ad0, 0);
    check("rst_wdata", wd0, 0);
    check("rst_busy", busy0, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", rdy0, 1);

    // write then read back
    rr0 = 1'b1;
    sb = slog.size(); rb = rlog.size();
    push0(1'b1, 3'd0, 2'b10);
    push0(1'b0, 3'd0, 2'b00);
    k = 0;
    while (rlog.size() == rb && k < 20) begin tick(); k++; end
    check("wr_rd_timeout", k < 20, 1);
    tick(); tick();
    check("wr_rd_nstrobe", slog.size() - sb, 2);
    if (slog.size() - sb == 2) begin
      check("wr_strobe", slog[sb], 6'b1_000_10);
      check("rd_strobe", slog[sb+1], 6'b0_000_10);
      check("wr_rd_spacing", scyc[sb+1] - scyc[sb], 2);
    end
    if (rlog.size() > rb) check("wr_rd_data", rlog[rb], 2'b10);

    // full FIFO with response backpressure
    rr0 = 1'b0;
    sb = slog.size(); rb = rlog.size();
    push0(1'b0, 3'd3, 2'b00);
    push0(1'b1, 3'd1, 2'b01);
    push0(1'b1, 3'd2, 2'b10);
    push0(1'b1, 3'd4, 2'b11);
    push0(1'b1, 3'd5, 2'b01);
    check("full_ready_low", rdy0, 0);
    v0 = 1'b1; wr0 = 1'b1; a0 = 3'd6; d0 = 2'b11;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rv0, 1);
      check("bp_data", rd0, 2'b11);
      tick();
    end
    v0 = 1'b0;
    check("bp_no_strobe", slog.size() - sb, 1);
    check("sixth_refused", rdy0, 0);
    rr0 = 1'b1;
    tick();
    hs = cyc;
    check("rsp_dropped", rv0, 0);
    repeat (10) tick();
    check("full_nstrobe", slog.size() - sb, 5);
    if (slog.size() - sb == 5)
      for (int i = 0; i < 4; i++) begin
        check("full_wr_order", slog[sb+1+i], wexp[i]);
        check("full_wr_cycle", scyc[sb+1+i], hs + 1 + 2*i);
      end

    // pointer wrap with alternating write/read pairs
    rb = rlog.size();
    for (int i = 0; i < 10; i++) begin
      push0(1'b1, 3'(i % 5), 2'((i + 1) % 4));
      push0(1'b0, 3'(i % 5), 2'b00);
      exp_q.push_back(2'((i + 1) % 4));
    end
    k = 0;
    while (rlog.size() - rb < 10 && k < 200) begin tick(); k++; end
    check("wrap_nrsp", rlog.size() - rb, 10);
    check("wrap_busy", busy0, 0);
    for (int i = 0; i < 10 && rb + i < rlog.size(); i++)
      check("wrap_rsp", rlog[rb+i], exp_q[i]);

    // read latency, RD_LAT=3
    rr1 = 1'b1;
    v1 = 1'b1; wr1 = 1'b0; a1 = 3'd5; d1 = 2'b00;
    check("lat_ready", rdy1, 1);
    tick();
    n = cyc;
    v1 = 1'b0;
    k = 0;
    while (!rv1 && k < 20) begin tick(); k++; end
    check("lat_cycles", cyc - n, 5);
    check("lat_data", rd1, 2'b01);
    tick(); tick();

    // reset while a read is waiting, two entries still queued
    v1 = 1'b1; wr1 = 1'b0; a1 = 3'd5; tick();
    a1 = 3'd4; tick();
    wr1 = 1'b1; a1 = 3'd2; d1 = 2'b11; tick();
    v1 = 1'b0;
    tick();
    check("pre_rst_busy", busy1, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_read", r1, 0);
    check("mid_rst_rsp", rv1, 0);
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_ready", rdy1, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("post_rst_ready", rdy1, 1);
    s1b = s1_cnt; rv1b = rv1_cnt;
    repeat (15) tick();
    check("post_rst_no_rsp", rv1_cnt - rv1b, 0);
    check("post_rst_no_strobe", s1_cnt - s1b, 0);
    check("post_rst_busy", busy1, 0);
    check("strobe_overlap", both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
